load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports: clk input 1; the single clock, rising edge.
REQ-002 The block SHALL have a_rst input 1; asynchronous, active-low reset.
REQ-003 The block SHALL have rq_start input 1; request valid from scheduling front.
REQ-004 The block SHALL have rq_cmd input 1; 1 = store, 0 = load.
REQ-005 The block SHALL have rq_width input 1; 1 = 16-bit, 0 = 8-bit.
REQ-006 The block SHALL have rq_tag input 1; originating station (0 = A, 1 = B).
REQ-007 The block SHALL have rq_addr input 16; effective address from the AGU.
REQ-008 The block SHALL have rq_data input 16; store data.
REQ-009 The block SHALL have lsu_wait output 1; busy, scheduler front holds.
REQ-010 The block SHALL have lsu_data_in output 16; load result.
REQ-011 The block SHALL have lsu_data_tag output 1; tag of the returned load.
REQ-012 The block SHALL have lsu_data_wb output 1; one-cycle load writeback strobe.
REQ-013 The block SHALL have mem_adr output 16; byte address on the memory bus.
REQ-014 The block SHALL have mem_dout output 8; byte written to memory.
REQ-015 The block SHALL have mem_din input 8; byte read from memory.
REQ-016 The block SHALL have mem_rd output 1; memory read strobe.
REQ-017 The block SHALL have mem_wr output 1; memory write strobe.
REQ-018 The block SHALL have mem_ready input 1; access completes at the rising edge where this is sampled high.

Function
REQ-019 The FSM SHALL have four states: IDLE, ACC_LO, ACC_HI, WB.
REQ-020 lsu_wait SHALL be combinational and SHALL equal (state != IDLE).
REQ-021 In IDLE, rq_start=1 at a rising edge SHALL capture cmd, width, tag, addr and data, and SHALL move to ACC_LO.
REQ-022 In ACC_LO, mem_adr SHALL be addr, mem_dout SHALL be data[7:0], and mem_rd or mem_wr SHALL be asserted according to cmd.
REQ-023 Strobes SHALL stay asserted until mem_ready is sampled high.
REQ-024 When ACC_LO completes, a load SHALL capture mem_din into result[7:0].
REQ-025 When ACC_LO completes, the next state SHALL be ACC_HI if width=1, else WB for a load, else IDLE for a store.
REQ-026 In ACC_HI, mem_adr SHALL be addr+1, mod 2^16, so 0xFFFF wraps to 0x0000.
REQ-027 In ACC_HI, mem_dout SHALL be data[15:8], and the strobe rule of REQ-023 SHALL apply.
REQ-028 When ACC_HI completes, a load SHALL capture result[15:8] and go to WB; a store SHALL go to IDLE.
REQ-029 Byte order SHALL be little-endian.
REQ-030 An 8-bit load SHALL return result[15:8]=0x00 (zero extension).
REQ-031 In WB, lsu_data_wb SHALL be 1 for exactly one cycle, with lsu_data_in=result and lsu_data_tag=captured tag; the next state SHALL be IDLE.
REQ-032 Outside WB, lsu_data_wb SHALL be 0.
REQ-033 In IDLE and WB, mem_rd and mem_wr SHALL be 0; mem_rd and mem_wr SHALL never both be 1.
REQ-034 rq_start SHALL be ignored while state != IDLE.
REQ-035 A request presented in the same cycle the FSM returns to IDLE SHALL be accepted at the following edge.
REQ-036 Minimum latency with mem_ready tied 1, counted from the accept edge to the WB cycle: byte load = 2 cycles; word load = 3 cycles.
REQ-037 Minimum occupancy with mem_ready tied 1: byte store = 1 access cycle; word store = 2 access cycles.
REQ-038 In IDLE, mem_adr and mem_dout SHALL hold their last values; they carry no meaning while both strobes are 0.

Reset
REQ-039 On a_rst low, asynchronously: state=IDLE, lsu_wait=0, lsu_data_wb=0, lsu_data_tag=0, lsu_data_in=0x0000, mem_rd=0, mem_wr=0, mem_adr=0x0000, mem_dout=0x00, and all captured registers cleared.
REQ-040 A reset asserted mid-access SHALL abort the access with no writeback and no further strobe.
REQ-041 After reset deassertion, the first rising edge SHALL be able to accept a request.

Structure
REQ-042 The state encoding (2-bit) and the command/width encodings SHALL live in the shared core package.
REQ-043 The block SHALL be a single module; the byte sequencing is integral to the FSM and no sub-module is required.

Verification
REQ-044 Byte load: rq_addr=0x1234, width=0, tag=1, mem_din=0xAB, mem_ready=1 -> mem_rd for 1 cycle at 0x1234; WB 2 cycles after accept with lsu_data_in=0x00AB and lsu_data_tag=1.
REQ-045 Word load with wrap: rq_addr=0xFFFF, width=1, bytes 0x34 then 0x12 -> accesses at 0xFFFF then 0x0000; lsu_data_in=0x1234 at WB.
REQ-046 Word store with wait states: rq_data=0xBEEF, addr=0x0200, mem_ready low for 2 cycles per byte -> 0xEF written to 0x0200 and 0xBE to 0x0201; lsu_wait high throughout; no lsu_data_wb.
REQ-047 Back-to-back: rq_start held high for two requests -> the second is accepted only after IDLE is reached; no strobe overlap; each load gets exactly one wb with the correct tag.
REQ-048 Reset mid-ACC_HI of a word load -> all outputs at reset values immediately; no lsu_data_wb after release.
REQ-049 Strobe check over random traffic: mem_rd & mem_wr never both 1; lsu_data_wb never high for 2 consecutive cycles.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings for the load/store unit
package load_store_unit_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC_LO = 2'd1;
    localparam logic [1:0] ST_ACC_HI = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    localparam logic CMD_LOAD   = 1'b0;
    localparam logic CMD_STORE  = 1'b1;
    localparam logic WIDTH_BYTE = 1'b0;
    localparam logic WIDTH_HALF = 1'b1;

    typedef struct packed {
        logic        cmd;
        logic        width;
        logic        tag;
        logic [15:0] addr;
        logic [15:0] data;
    } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store sequencer for 8/16-bit accesses
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        a_rst,
    input  logic        rq_start,
    input  logic        rq_cmd,
    input  logic        rq_width,
    input  logic        rq_tag,
    input  logic [15:0] rq_addr,
    input  logic [15:0] rq_data,
    output logic        lsu_wait,
    output logic [15:0] lsu_data_in,
    output logic        lsu_data_tag,
    output logic        lsu_data_wb,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready
);

    logic [1:0]  state;
    lsu_req_t    req;
    logic [15:0] result;
    logic        in_access;

    // Address/data bus registers are loaded on state entry so they hold across IDLE.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state    <= ST_IDLE;
            req      <= '0;
            result   <= '0;
            mem_adr  <= '0;
            mem_dout <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rq_start) begin
                        req      <= '{cmd: rq_cmd, width: rq_width, tag: rq_tag,
                                      addr: rq_addr, data: rq_data};
                        result   <= '0;
                        mem_adr  <= rq_addr;
                        mem_dout <= rq_data[7:0];
                        state    <= ST_ACC_LO;
                    end
                end
                ST_ACC_LO: begin
                    if (mem_ready) begin
                        if (req.cmd == CMD_LOAD) begin
                            result[7:0] <= mem_din;
                        end
                        if (req.width == WIDTH_HALF) begin
                            mem_adr  <= req.addr + 16'd1;
                            mem_dout <= req.data[15:8];
                            state    <= ST_ACC_HI;
                        end else begin
                            state <= (req.cmd == CMD_LOAD) ? ST_WB : ST_IDLE;
                        end
                    end
                end
                ST_ACC_HI: begin
                    if (mem_ready) begin
                        if (req.cmd == CMD_LOAD) begin
                            result[15:8] <= mem_din;
                        end
                        state <= (req.cmd == CMD_LOAD) ? ST_WB : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_access    = (state == ST_ACC_LO) || (state == ST_ACC_HI);
    assign mem_rd       = in_access && (req.cmd == CMD_LOAD);
    assign mem_wr       = in_access && (req.cmd == CMD_STORE);
    assign lsu_wait     = (state != ST_IDLE);
    assign lsu_data_wb  = (state == ST_WB);
    assign lsu_data_in  = result;
    assign lsu_data_tag = req.tag;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        a_rst = 1'b0;
    logic        rq_start = 1'b0;
    logic        rq_cmd = 1'b0;
    logic        rq_width = 1'b0;
    logic        rq_tag = 1'b0;
    logic [15:0] rq_addr = '0;
    logic [15:0] rq_data = '0;
    logic        lsu_wait;
    logic [15:0] lsu_data_in;
    logic        lsu_data_tag;
    logic        lsu_data_wb;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem_model [0:65535];
    logic [7:0]  shadow [0:15];
    int          ws_cfg = 0;
    int          ws_cnt = 0;
    logic        prev_wb = 1'b0;

    logic [24:0] exp_acc [$];   // {is_write, address, write byte}
    logic [16:0] exp_wb  [$];   // {tag, data}

    load_store_unit dut (
        .clk(clk), .a_rst(a_rst), .rq_start(rq_start), .rq_cmd(rq_cmd),
        .rq_width(rq_width), .rq_tag(rq_tag), .rq_addr(rq_addr), .rq_data(rq_data),
        .lsu_wait(lsu_wait), .lsu_data_in(lsu_data_in), .lsu_data_tag(lsu_data_tag),
        .lsu_data_wb(lsu_data_wb), .mem_adr(mem_adr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_din   = mem_model[mem_adr];
    assign mem_ready = (ws_cnt >= ws_cfg);

    always @(posedge clk) begin
        if (!(mem_rd || mem_wr) || mem_ready) ws_cnt <= 0;
        else ws_cnt <= ws_cnt + 1;
        if (mem_wr && mem_ready) mem_model[mem_adr] <= mem_dout;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a bus access or writes back.
    always @(negedge clk) begin
        chk("strobe_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
        chk("wb_not_consecutive", {31'd0, prev_wb & lsu_data_wb}, 32'd0);
        prev_wb = lsu_data_wb;
        if ((mem_rd || mem_wr) && mem_ready && a_rst) begin
            if (exp_acc.size() == 0) begin
                chk("unexpected_access", {15'd0, mem_wr, mem_adr}, 32'h1ffff);
            end else begin
                logic [24:0] e;
                e = exp_acc.pop_front();
                chk("acc_dir", {31'd0, mem_wr}, {31'd0, e[24]});
                chk("acc_adr", {16'd0, mem_adr}, {16'd0, e[23:8]});
                if (e[24]) chk("acc_dout", {24'd0, mem_dout}, {24'd0, e[7:0]});
            end
        end
        if (lsu_data_wb) begin
            if (exp_wb.size() == 0) begin
                chk("unexpected_wb", {15'd0, lsu_data_tag, lsu_data_in}, 32'h1ffff);
            end else begin
                logic [16:0] w;
                w = exp_wb.pop_front();
                chk("wb_data", {16'd0, lsu_data_in}, {16'd0, w[15:0]});
                chk("wb_tag", {31'd0, lsu_data_tag}, {31'd0, w[16]});
            end
        end
    end

    task automatic wait_idle(output int busy);
        busy = 0;
        while (lsu_wait && busy < 200) begin
            busy++;
            @(posedge clk); #1;
        end
        if (busy >= 200) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic cmd, input logic width, input logic tag,
                         input logic [15:0] addr, input logic [15:0] data, input int exp_busy);
        int busy;
        chk("idle_before_issue", {31'd0, lsu_wait}, 32'd0);
        rq_cmd = cmd; rq_width = width; rq_tag = tag; rq_addr = addr; rq_data = data;
        rq_start = 1'b1;
        @(posedge clk); #1;
        rq_start = 1'b0;
        wait_idle(busy);
        chk("busy_cycles", busy, exp_busy);
    endtask

    initial begin
        int busy;
        int guard;
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
        mem_model[16'h1234] = 8'hAB;
        mem_model[16'hFFFF] = 8'h34;
        mem_model[16'h0000] = 8'h12;
        mem_model[16'h0010] = 8'h5A;
        mem_model[16'h0300] = 8'h11;
        mem_model[16'h0301] = 8'h22;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 8'(i * 17 + 3);
            mem_model[16'h0400 + 16'(i)] = shadow[i];
        end

        #12;
        chk("rst_wait", {31'd0, lsu_wait}, 32'd0);
        chk("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst_adr", {16'd0, mem_adr}, 32'd0);
        chk("rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_data_in", {16'd0, lsu_data_in}, 32'd0);
        chk("rst_wb_tag", {30'd0, lsu_data_wb, lsu_data_tag}, 32'd0);
        @(posedge clk); #1;
        a_rst = 1'b1;

        // byte load, zero extended
        exp_acc.push_back({1'b0, 16'h1234, 8'h00});
        exp_wb.push_back({1'b1, 16'h00AB});
        issue(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 2);

        // word load wrapping 0xFFFF -> 0x0000
        exp_acc.push_back({1'b0, 16'hFFFF, 8'h00});
        exp_acc.push_back({1'b0, 16'h0000, 8'h00});
        exp_wb.push_back({1'b0, 16'h1234});
        issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 3);

        // word store with two wait states per byte
        ws_cfg = 2;
        exp_acc.push_back({1'b1, 16'h0200, 8'hEF});
        exp_acc.push_back({1'b1, 16'h0201, 8'hBE});
        issue(1'b1, 1'b1, 1'b0, 16'h0200, 16'hBEEF, 6);
        chk("store_lo_mem", {24'd0, mem_model[16'h0200]}, 32'hEF);
        chk("store_hi_mem", {24'd0, mem_model[16'h0201]}, 32'hBE);
        ws_cfg = 0;

        // byte store, single access cycle
        exp_acc.push_back({1'b1, 16'h0202, 8'h99});
        issue(1'b1, 1'b0, 1'b1, 16'h0202, 16'h4499, 1);
        chk("byte_store_mem", {24'd0, mem_model[16'h0202]}, 32'h99);
        chk("byte_store_neighbour", {24'd0, mem_model[16'h0203]}, 32'h00);

        // back-to-back with rq_start held high
        exp_acc.push_back({1'b0, 16'h0010, 8'h00});
        exp_wb.push_back({1'b0, 16'h005A});
        exp_acc.push_back({1'b1, 16'h0020, 8'h77});
        rq_cmd = 1'b0; rq_width = 1'b0; rq_tag = 1'b0; rq_addr = 16'h0010; rq_data = 16'h0000;
        rq_start = 1'b1;
        @(posedge clk); #1;
        rq_cmd = 1'b1; rq_tag = 1'b1; rq_addr = 16'h0020; rq_data = 16'h0077;
        wait_idle(busy);
        chk("b2b_first_busy", busy, 2);
        @(posedge clk); #1;
        rq_start = 1'b0;
        chk("b2b_second_accepted", {31'd0, lsu_wait}, 32'd1);
        wait_idle(busy);
        chk("b2b_second_busy", busy, 1);
        chk("b2b_store_mem", {24'd0, mem_model[16'h0020]}, 32'h77);

        // reset in the middle of the high byte of a word load
        ws_cfg = 2;
        exp_acc.push_back({1'b0, 16'h0300, 8'h00});
        rq_cmd = 1'b0; rq_width = 1'b1; rq_tag = 1'b1; rq_addr = 16'h0300;
        rq_start = 1'b1;
        @(posedge clk); #1;
        rq_start = 1'b0;
        guard = 0;
        while (!(mem_rd && mem_adr == 16'h0301) && guard < 50) begin
            guard++;
            @(posedge clk); #1;
        end
        chk("reached_acc_hi", {31'd0, mem_rd && mem_adr == 16'h0301}, 32'd1);
        @(posedge clk); #3;
        a_rst = 1'b0;
        #1;
        chk("abort_wait", {31'd0, lsu_wait}, 32'd0);
        chk("abort_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("abort_adr", {16'd0, mem_adr}, 32'd0);
        chk("abort_data_in", {16'd0, lsu_data_in}, 32'd0);
        chk("abort_wb_tag", {30'd0, lsu_data_wb, lsu_data_tag}, 32'd0);
        ws_cfg = 0;
        @(posedge clk); #1;
        a_rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // first edge after reset release accepts a request
        a_rst = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b1;
        exp_acc.push_back({1'b0, 16'h0301, 8'h00});
        exp_wb.push_back({1'b1, 16'h0022});
        issue(1'b0, 1'b0, 1'b1, 16'h0301, 16'h0000, 2);

        // random traffic against a shadow of 0x0400..0x040F
        for (int k = 0; k < 12; k++) begin
            logic       c, w, t;
            logic [3:0] off;
            logic [15:0] d, a;
            int         ws, exp_busy;
            c = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            off = 4'($urandom_range(0, 14));
            d = 16'($urandom);
            ws = $urandom_range(0, 2);
            a = 16'h0400 + {12'd0, off};
            ws_cfg = ws;
            exp_acc.push_back({c, a, d[7:0]});
            if (w) exp_acc.push_back({c, a + 16'd1, d[15:8]});
            if (c) begin
                shadow[off] = d[7:0];
                if (w) shadow[off + 4'd1] = d[15:8];
                exp_busy = (w ? 2 : 1) * (ws + 1);
            end else begin
                exp_wb.push_back({t, (w ? shadow[off + 4'd1] : 8'h00), shadow[off]});
                exp_busy = (w ? 2 : 1) * (ws + 1) + 1;
            end
            issue(c, w, t, a, d, exp_busy);
        end
        ws_cfg = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("wb_queue_drained", exp_wb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
